// File: rtl/regfile_sb.sv
// Parametrised register file with one write port, two combinational read ports,
// optional write-to-read forwarding and a per-register busy (scoreboard) bit.
module regfile_sb #(
  parameter int WIDTH   = 14,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic             ra_busy,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_busy,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [DEPTH-1:0] busy_vec,
  output logic             err,
  input  logic             err_clr
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             err_q;

  logic             w_in_range;
  logic             rsv_in_range;
  logic             w_zero;
  logic             rsv_zero;
  logic             w_hit;
  logic             rsv_hit;
  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] rsv_sel;
  logic             rsv_cur_busy;
  logic             err_w_oor;
  logic             err_rsv_oor;
  logic             err_dbl;
  logic             new_err;

  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic             ra_b;
  logic             rb_b;

  // Address qualification: out-of-range and (optionally) hardwired r0 accesses never touch state.
  always_comb begin
    w_in_range   = ({1'b0, w_addr} < DEPTH_W);
    rsv_in_range = ({1'b0, rsv_addr} < DEPTH_W);
    w_zero       = ZERO_R0 && (w_addr == '0);
    rsv_zero     = ZERO_R0 && (rsv_addr == '0);
    w_hit        = w_en && w_in_range && !w_zero;
    rsv_hit      = rsv_en && rsv_in_range && !rsv_zero;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_decode
    assign w_sel[g]   = w_hit && (w_addr == AW'(g));
    assign rsv_sel[g] = rsv_hit && (rsv_addr == AW'(g));
  end

  always_comb begin
    rsv_cur_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rsv_addr == AW'(i)) rsv_cur_busy = busy[i];
    end
  end

  // A reservation onto a busy register is only legal when that register is being written back this cycle.
  always_comb begin
    err_w_oor   = w_en && !w_in_range;
    err_rsv_oor = rsv_en && !rsv_in_range;
    err_dbl     = rsv_hit && rsv_cur_busy && !(w_hit && (w_addr == rsv_addr));
    new_err     = err_w_oor || err_rsv_oor || err_dbl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_sel[i]) regs[i] <= w_data;
      end
    end
  end

  // Reserve is applied after release so a same-cycle new producer leaves the register busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= (busy & ~w_sel) | rsv_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_q <= 1'b0;
    else if (new_err) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  always_comb begin
    ra_q = '0;
    ra_b = 1'b0;
    rb_q = '0;
    rb_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra_addr == AW'(i)) begin
        ra_q = regs[i];
        ra_b = busy[i];
      end
      if (rb_addr == AW'(i)) begin
        rb_q = regs[i];
        rb_b = busy[i];
      end
    end
    if (BYPASS && w_hit && (w_addr == ra_addr)) begin
      ra_q = w_data;
      ra_b = 1'b0;
    end
    if (BYPASS && w_hit && (w_addr == rb_addr)) begin
      rb_q = w_data;
      rb_b = 1'b0;
    end
    if (!rst) begin
      ra_q = '0;
      ra_b = 1'b0;
      rb_q = '0;
      rb_b = 1'b0;
    end
  end

  assign ra_data  = ra_q;
  assign ra_busy  = ra_b;
  assign rb_data  = rb_q;
  assign rb_busy  = rb_b;
  assign busy_vec = rst ? busy : '0;
  assign err      = err_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file for the 14-bit CPU datapath. It supersedes the per-register enable/select instances.
- Provides DEPTH registers of WIDTH bits, one write port, two read ports and optional write-to-read forwarding.
- Each register has a busy (scoreboard) bit: a register is reserved at issue and released by its write-back.
- A sticky error flag reports illegal accesses to control logic.

Parameters:
- WIDTH, 14, data width of each register.
- DEPTH, 8, number of registers; legal range 2..2^AW.
- AW, 3, address width; addresses >= DEPTH are out of range.
- ZERO_R0, 0, 1 = register 0 reads as zero, ignores writes and can never be busy.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- w_en  in  1  write strobe (write-back).
- w_addr  in  AW  write address.
- w_data  in  WIDTH  write data.
- ra_addr  in  AW  read port A address.
- ra_data  out  WIDTH  read port A data (combinational).
- ra_busy  out  1  busy bit of the register at ra_addr.
- rb_addr  in  AW  read port B address.
- rb_data  out  WIDTH  read port B data.
- rb_busy  out  1  busy bit of the register at rb_addr.
- rsv_en  in  1  reserve strobe (issue).
- rsv_addr  in  AW  register to mark busy.
- busy_vec  out  DEPTH  all busy bits; bit i belongs to register i.
- err  out  1  sticky error flag.
- err_clr  in  1  clears err.

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all busy bits = 0, err = 0, effective immediately.
  - While rst=0: ra_data/rb_data = 0, ra_busy/rb_busy = 0, busy_vec = 0, forwarding suppressed.
  - On release, state is updated from the first rising edge after rst goes to 1.
- Write: at a rising edge with w_en=1 and w_addr < DEPTH, reg[w_addr] <= w_data and busy[w_addr] <= 0. Latency is 1 cycle without bypass.
- Reserve: at a rising edge with rsv_en=1 and rsv_addr < DEPTH, busy[rsv_addr] <= 1.
- Write and reserve to the same address in the same cycle: data is written and busy ends at 1, because the new producer wins.
- Reads are combinational: rX_data = reg[rX_addr], rX_busy = busy[rX_addr].
  - An out-of-range rX_addr gives data 0 and busy 0, with no error.
- BYPASS=1: if w_en=1 and w_addr == rX_addr (in range, not a zeroed r0), then rX_data = w_data and rX_busy = 0 in the same cycle.
  - This holds even if rsv_en targets the same address that cycle, since the reservation is visible only from the next cycle.
- BYPASS=0: read ports show pre-edge contents only.
- ZERO_R0=1: a write to r0 is dropped silently; a reserve of r0 is dropped silently; r0 always reads 0 and not busy; busy_vec[0] = 0. None of these raise err.
- Error sources, sampled at the rising edge; any one sets err <= 1:
  - (a) w_en=1 with w_addr >= DEPTH; the write is discarded.
  - (b) rsv_en=1 with rsv_addr >= DEPTH; the reserve is discarded.
  - (c) rsv_en=1 to a register that is already busy and is not being written the same cycle (double reservation). Busy stays 1.
- err clearing: err stays high until an edge with err_clr=1 and no new error. If err_clr and a new error occur in the same cycle, err ends at 1.
- Simultaneous write and read on both ports to the same register is legal; both ports see identical values.
- Busy bits and register contents are independent: a write to a non-busy register is legal and raises no error.

Test Plan:
- Reset, then write 14'h1ABC to r3 and reserve r5 in the same cycle → next cycle ra_addr=3 gives 14'h1ABC/busy 0; rb_addr=5 gives busy 1; busy_vec=8'b0010_0000.
- BYPASS=1: w_en=1, w_addr=2, w_data=14'h0155, ra_addr=2, all in one cycle → ra_data=14'h0155 and ra_busy=0 before the edge.
  - Repeat with BYPASS=0 → old value shown until the edge.
- Reserve r4, then next cycle write r4=14'h3FFF with rsv_en=1, rsv_addr=4 → r4=14'h3FFF, busy[4]=1, err=0.
- Reserve r6 twice on consecutive cycles without a write → err=1 after the 2nd edge.
  - Then err_clr=1 → err=0 next cycle.
  - err_clr=1 together with another double reserve → err stays 1.
- DEPTH=6, AW=3: write to address 7 → no register changes, err=1. Read of address 7 → data 0, busy 0.
- ZERO_R0=1: write 14'h0011 to r0 and reserve r0 → r0 reads 0, busy_vec[0]=0, err=0.
  - Then assert rst=0 mid-cycle after loading r1=14'h2222 with r1 busy → all outputs 0 immediately, no edge needed.
